// File: rtl/pll_supervisor_pkg.sv
// pll_supervisor_pkg
//   Shared types and widths for the PLL supervisor: the controller state
//   encoding, the retry/loss counter widths and a small helper used to
//   size the shared timer.
package pll_supervisor_pkg;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  typedef enum logic [2:0] {
    S_PRST,    // PLL held in reset
    S_WAIT,    // waiting for lock, timeout running
    S_STABLE,  // lock seen, qualifying stability window
    S_RUN,     // qualified lock, downstream domain released
    S_FAULT    // retries exhausted, parked until reset
  } pll_sup_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// bit_sync_2ff
//   Two-flop synchronizer for a single asynchronous level signal.
//   Both flops reset to 0.
// Ports:
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset
//   d_i    - asynchronous input level
//   q_o    - synchronized level, two clk_i edges behind d_i
module bit_sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: state elements use non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the two
  // stages into one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// pll_supervisor
//   Drives the PLL reset, waits for lock with a per-attempt timeout,
//   qualifies lock over a stability window and then releases the video
//   domain. Lock losses in RUN are counted; too many failed lock attempts
//   park the block in a sticky fault.
// Ports:
//   refclk       - reference clock, the only clock
//   rst          - synchronous active-high reset
//   pll_locked   - PLL locked, asynchronous, synchronized internally
//   clear_counts - one-cycle pulse, zeroes loss_count
//   pll_rst      - PLL reset
//   domain_rst   - reset request to the video domain (high unless RUN)
//   ready        - qualified lock (high only in RUN)
//   fault        - retries exhausted, sticky until rst
//   retry_count  - failed attempts since last entry to RUN
//   loss_count   - lock losses in RUN, saturating
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               clear_counts,
  output logic               pll_rst,
  output logic               domain_rst,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [LOSS_W-1:0]  loss_count
);

  localparam int TW = $clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES));

  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
  // The lk sample that moves WAIT to STABLE is the first sample of the
  // stability window, so STABLE itself needs STABLE_CYCLES-1 more samples.
  localparam logic [TW-1:0] STABLE_LAST =
    TW'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);
  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRIES);

  logic lk;

  bit_sync_2ff u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lk)
  );

  pll_sup_state_t     state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               pll_rst_q, pll_rst_d;
  logic               domain_rst_q, domain_rst_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic               loss_event;

  // NOTE: every signal driven here is given a default before the case so no
  // path leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + TW'(1);
    retry_d    = retry_q;
    loss_event = 1'b0;

    unique case (state_q)
      S_PRST: begin
        if (timer_q == RST_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Lock is checked first so it wins over a coincident timeout.
        if (lk) begin
          state_d = S_STABLE;
        end else if (timer_q == LOCK_LAST) begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = (retry_d == MAX_R) ? S_FAULT : S_PRST;
        end
      end
      S_STABLE: begin
        if (!lk) begin
          state_d = S_WAIT;
        end else if (timer_q == STABLE_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        timer_d = '0;
        if (!lk) begin
          state_d    = S_PRST;
          loss_event = 1'b1;
        end
      end
      S_FAULT: begin
        timer_d = '0;
      end
      default: begin
        state_d = S_PRST;
      end
    endcase

    if (state_d != state_q) timer_d = '0;

    loss_d = loss_q;
    if (loss_event && (loss_q != '1)) loss_d = loss_q + LOSS_W'(1);
    // A clear that coincides with a loss keeps that loss.
    if (clear_counts) loss_d = loss_event ? LOSS_W'(1) : '0;

    // Outputs are registered from the next state so they change on the
    // same edge as the state register.
    pll_rst_d    = (state_d == S_PRST) || (state_d == S_FAULT);
    domain_rst_d = (state_d != S_RUN);
    ready_d      = (state_d == S_RUN);
    fault_d      = (state_d == S_FAULT);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= S_PRST;
      timer_q      <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_rst_q    <= pll_rst_d;
      domain_rst_q <= domain_rst_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign domain_rst  = domain_rst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// tb_pll_supervisor
//   Directed bench for pll_supervisor with RST_CYCLES=4, LOCK_TIMEOUT=100,
//   STABLE_CYCLES=8, MAX_RETRIES=3. Inputs change and outputs are sampled
//   1 ns after each rising edge; a value driven after step k is first seen
//   by the DUT at edge k+1.
module tb_pll_supervisor;
  import pll_supervisor_pkg::*;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 100;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 3;

  logic               refclk = 1'b0;
  logic               rst = 1'b1;
  logic               pll_locked = 1'b0;
  logic               clear_counts = 1'b0;
  logic               pll_rst, domain_rst, ready, fault;
  logic [RETRY_W-1:0] retry_count;
  logic [LOSS_W-1:0]  loss_count;

  int checks = 0;
  int failures = 0;

  pll_supervisor #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .clear_counts (clear_counts),
    .pll_rst      (pll_rst),
    .domain_rst   (domain_rst),
    .ready        (ready),
    .fault        (fault),
    .retry_count  (retry_count),
    .loss_count   (loss_count)
  );

  always #10 refclk = ~refclk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // Steps until ready is high or the budget runs out; n = steps taken.
  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (!ready && n < limit) begin
      step(1);
      n++;
    end
  endtask

  // One-cycle drop of pll_locked from RUN, then wait for the relock.
  task automatic lose_and_relock();
    int n;
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(2);
    wait_ready(40, n);
  endtask

  task automatic test_reset();
    pll_locked = 1'b0;
    clear_counts = 1'b0;
    rst = 1'b1;
    step(3);
    checks++;
    if ({pll_rst, domain_rst, ready, fault} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 1100", {pll_rst, domain_rst, ready, fault});
    end
    checks++;
    if (retry_count !== 4'd0 || loss_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_counts: got retry=%0d loss=%0d expected 0 0", retry_count, loss_count);
    end
  endtask

  task automatic test_clean_lock();
    int n;
    pll_locked = 1'b0;
    do_reset();
    for (int k = 1; k <= RST_CYCLES; k++) begin
      step(1);
      checks++;
      if (pll_rst !== 1'(k < RST_CYCLES)) begin
        failures++;
        $display("FAIL clean_pll_rst_k%0d: got %b expected %b", k, pll_rst, 1'(k < RST_CYCLES));
      end
    end
    step(20);
    pll_locked = 1'b1;
    wait_ready(30, n);
    checks++;
    if (n !== 10) begin
      failures++;
      $display("FAIL clean_ready_latency: got %0d cycles expected 10", n);
    end
    checks++;
    if (retry_count !== 4'd0 || domain_rst !== 1'b0 || pll_rst !== 1'b0) begin
      failures++;
      $display("FAIL clean_run_outputs: got retry=%0d domain_rst=%b pll_rst=%b expected 0 0 0",
               retry_count, domain_rst, pll_rst);
    end
  endtask

  task automatic test_loss_in_run();
    int n;
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL loss_ready_early: got %b expected 1 two cycles after drop", ready);
    end
    step(1);
    checks++;
    if ({ready, domain_rst, pll_rst} !== 3'b011 || loss_count !== 8'd1) begin
      failures++;
      $display("FAIL loss_response: got rdy/drst/prst=%b loss=%0d expected 011 1",
               {ready, domain_rst, pll_rst}, loss_count);
    end
    // Relock: 4 cycles PRST, 1 WAIT, 7 STABLE.
    wait_ready(40, n);
    checks++;
    if (n !== 12 || retry_count !== 4'd0) begin
      failures++;
      $display("FAIL loss_relock: got %0d cycles retry=%0d expected 12 0", n, retry_count);
    end
    repeat (4) lose_and_relock();
    checks++;
    if (loss_count !== 8'd5 || ready !== 1'b1) begin
      failures++;
      $display("FAIL loss_five: got loss=%0d ready=%b expected 5 1", loss_count, ready);
    end
  endtask

  task automatic test_clear_collision();
    int n;
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    clear_counts = 1'b1;
    step(1);
    clear_counts = 1'b0;
    checks++;
    if (loss_count !== 8'd1 || ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_collision: got loss=%0d ready=%b expected 1 0", loss_count, ready);
    end
    wait_ready(40, n);
    clear_counts = 1'b1;
    step(1);
    clear_counts = 1'b0;
    checks++;
    if (loss_count !== 8'd0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_plain: got loss=%0d ready=%b expected 0 1", loss_count, ready);
    end
  endtask

  task automatic test_loss_saturation();
    repeat (255) lose_and_relock();
    checks++;
    if (loss_count !== 8'd255) begin
      failures++;
      $display("FAIL sat_255: got %0d expected 255", loss_count);
    end
    repeat (45) lose_and_relock();
    checks++;
    if (loss_count !== 8'd255 || ready !== 1'b1) begin
      failures++;
      $display("FAIL sat_300: got loss=%0d ready=%b expected 255 1", loss_count, ready);
    end
  endtask

  task automatic test_rst_mid_stable();
    // From RUN: drop, PRST (4), WAIT (1), then two cycles into STABLE.
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(2);
    step(6);
    checks++;
    if (ready !== 1'b0 || pll_rst !== 1'b0 || loss_count === 8'd0) begin
      failures++;
      $display("FAIL mid_stable_pre: got ready=%b pll_rst=%b loss=%0d expected 0 0 nonzero",
               ready, pll_rst, loss_count);
    end
    rst = 1'b1;
    step(1);
    checks++;
    if ({pll_rst, domain_rst, ready, fault} !== 4'b1100 ||
        retry_count !== 4'd0 || loss_count !== 8'd0) begin
      failures++;
      $display("FAIL mid_stable_rst: got flags=%b retry=%0d loss=%0d expected 1100 0 0",
               {pll_rst, domain_rst, ready, fault}, retry_count, loss_count);
    end
    pll_locked = 1'b0;
    step(2);
  endtask

  task automatic test_glitchy_lock();
    int n;
    logic seen_ready;
    pll_locked = 1'b0;
    do_reset();
    step(RST_CYCLES + 20);
    seen_ready = 1'b0;
    pll_locked = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step(1);
      seen_ready |= ready;
      if (k == 4) pll_locked = 1'b0;
    end
    pll_locked = 1'b1;
    checks++;
    if (seen_ready !== 1'b0) begin
      failures++;
      $display("FAIL glitch_no_ready: got ready seen=%b expected 0", seen_ready);
    end
    wait_ready(30, n);
    checks++;
    if (n !== 10 || retry_count !== 4'd0) begin
      failures++;
      $display("FAIL glitch_final: got %0d cycles retry=%0d expected 10 0", n, retry_count);
    end
  endtask

  task automatic test_never_locks();
    int pulses;
    logic prev, held;
    pll_locked = 1'b0;
    do_reset();
    pulses = 1;
    prev = pll_rst;
    for (int k = 1; k <= 312; k++) begin
      step(1);
      if (k <= 311 && pll_rst && !prev) pulses++;
      prev = pll_rst;
      if (k == 104 || k == 208) begin
        checks++;
        if (retry_count !== 4'(k / 104) || fault !== 1'b0) begin
          failures++;
          $display("FAIL never_retry_k%0d: got retry=%0d fault=%b expected %0d 0",
                   k, retry_count, fault, k / 104);
        end
      end
      if (k == 311) begin
        checks++;
        if (fault !== 1'b0) begin
          failures++;
          $display("FAIL never_fault_early: got %b expected 0 at cycle 311", fault);
        end
      end
    end
    checks++;
    if (pulses !== 3) begin
      failures++;
      $display("FAIL never_pulses: got %0d expected 3", pulses);
    end
    checks++;
    if (fault !== 1'b1 || retry_count !== 4'd3 || pll_rst !== 1'b1 ||
        ready !== 1'b0 || domain_rst !== 1'b1) begin
      failures++;
      $display("FAIL never_fault: got fault=%b retry=%0d pll_rst=%b ready=%b drst=%b expected 1 3 1 0 1",
               fault, retry_count, pll_rst, ready, domain_rst);
    end
    // Fault is sticky even if the PLL eventually locks.
    held = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if (k == 100) pll_locked = 1'b1;
      step(1);
      if (fault !== 1'b1 || pll_rst !== 1'b1 || ready !== 1'b0 || retry_count !== 4'd3)
        held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin
      failures++;
      $display("FAIL never_sticky: got held=%b expected 1", held);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_loss_in_run();
    test_clear_collision();
    test_loss_saturation();
    test_rst_mid_stable();
    test_glitchy_lock();
    test_never_locks();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
